// File: rtl/spi_multi_bridge.sv
// spi_multi_bridge: routes one SPI controller to NUM_CHIPS peripherals.
// Chip selection changes only between frames, through a valid/ready handshake
// followed by an all-deselected guard gap. Protocol violations set a sticky
// error flag, and completed frames are counted with saturation.
// Optional feature macro: SPI_BRIDGE_BROADCAST_EN (adds the bcast input; when
// bcast is set, a frame is driven to every chip).
module spi_multi_bridge #(
  parameter int unsigned NUM_CHIPS    = 2,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned SEL_W       = $clog2(NUM_CHIPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     sel_idx,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  output logic [SEL_W-1:0]     active_idx,
  input  logic                 cs_b,
  output logic [NUM_CHIPS-1:0] cs_b_chip,
  input  logic [NUM_CHIPS-1:0] poci_chip,
  output logic                 poci,
  output logic                 busy,
  output logic                 err_sel,
  input  logic                 err_clr,
`ifdef SPI_BRIDGE_BROADCAST_EN
  input  logic                 bcast,
`endif
  output logic [CNT_W-1:0]     xfer_count
);

  localparam int unsigned SEL_X      = SEL_W + 1;
  localparam int unsigned GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam int unsigned GW         = (GUARD_LAST > 0) ? $clog2(GUARD_LAST + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GUARD, S_BLOCK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] guard_cnt;
  logic          do_switch;
  logic          err_set;
  logic          frame_done;
  logic          frame_start;
  logic          idx_bad;

  // Requested index lies outside the populated chip range
  assign idx_bad = ({1'b0, sel_idx} >= SEL_X'(NUM_CHIPS));

  // State register; BLOCK after reset so an in-flight frame is never forwarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BLOCK;
    else     state <= state_nxt;
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_nxt   = state;
    do_switch   = 1'b0;
    err_set     = 1'b0;
    frame_done  = 1'b0;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cs_b) begin
          state_nxt   = S_XFER;
          frame_start = 1'b1;
        end else if (sel_valid) begin
          if (idx_bad) begin
            err_set = 1'b1;
          end else if (sel_idx != active_idx) begin
            do_switch = 1'b1;
            if (GUARD_CYCLES != 0) state_nxt = S_GUARD;
          end
        end
      end
      S_XFER: begin
        if (cs_b) begin
          state_nxt  = S_IDLE;
          frame_done = 1'b1;
        end
      end
      S_GUARD: begin
        if (!cs_b) begin
          err_set   = 1'b1;
          state_nxt = S_BLOCK;
        end else if (guard_cnt == GW'(GUARD_LAST)) begin
          state_nxt = S_IDLE;
        end
      end
      S_BLOCK: begin
        if (cs_b) state_nxt = S_IDLE;
      end
      default: state_nxt = S_BLOCK;
    endcase
  end

`ifdef SPI_BRIDGE_BROADCAST_EN
  logic bcast_q;
  logic bcast_use;

  // Broadcast mode is latched at frame start and held for the whole frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              bcast_q <= 1'b0;
    else if (frame_start) bcast_q <= bcast;
  end

  // While idle the live input decides, so every chip falls together with cs_b
  assign bcast_use = (state == S_IDLE) ? bcast : bcast_q;
`endif

  // Routed index, guard counter, sticky error and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_idx <= '0;
      guard_cnt  <= '0;
      err_sel    <= 1'b0;
      xfer_count <= '0;
    end else begin
      if (do_switch) begin
        active_idx <= sel_idx;
        guard_cnt  <= '0;
      end else if (state == S_GUARD) begin
        guard_cnt  <= guard_cnt + GW'(1);
      end
      if (err_set)      err_sel <= 1'b1;
      else if (err_clr) err_sel <= 1'b0;
      if (frame_done && (xfer_count != {CNT_W{1'b1}}))
        xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  // Pin outputs: chip selects and POCI are gated by registered state only
  always_comb begin
    cs_b_chip = '1;
    poci      = 1'b0;
    sel_ready = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE, S_XFER: begin
        cs_b_chip[active_idx] = cs_b;
`ifdef SPI_BRIDGE_BROADCAST_EN
        if (bcast_use) cs_b_chip = {NUM_CHIPS{cs_b}};
`endif
        if (state == S_IDLE) sel_ready = cs_b;
        else                 poci      = poci_chip[active_idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_multi_bridge.sv
// Directed bench for spi_multi_bridge: a 4-chip instance with a 2-cycle guard
// and a 3-chip instance with no guard and a 2-bit saturating frame counter.
module tb_spi_multi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]  sel_idx;
  logic        sel_valid;
  logic        sel_ready;
  logic [1:0]  active_idx;
  logic        cs_b;
  logic [3:0]  cs_b_chip;
  logic [3:0]  poci_chip;
  logic        poci;
  logic        busy;
  logic        err_sel;
  logic        err_clr;
  logic [15:0] xfer_count;

  logic [1:0]  sel_idx3;
  logic        sel_valid3;
  logic        sel_ready3;
  logic [1:0]  active_idx3;
  logic        cs_b3;
  logic [2:0]  cs_b_chip3;
  logic [2:0]  poci_chip3;
  logic        poci3;
  logic        busy3;
  logic        err_sel3;
  logic        err_clr3;
  logic [1:0]  xfer_count3;

`ifdef SPI_BRIDGE_BROADCAST_EN
  logic bcast;
  logic bcast3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  spi_multi_bridge #(.NUM_CHIPS(4), .GUARD_CYCLES(2), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst),
    .sel_idx(sel_idx), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .active_idx(active_idx), .cs_b(cs_b), .cs_b_chip(cs_b_chip),
    .poci_chip(poci_chip), .poci(poci), .busy(busy),
    .err_sel(err_sel), .err_clr(err_clr),
`ifdef SPI_BRIDGE_BROADCAST_EN
    .bcast(bcast),
`endif
    .xfer_count(xfer_count)
  );

  spi_multi_bridge #(.NUM_CHIPS(3), .GUARD_CYCLES(0), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst),
    .sel_idx(sel_idx3), .sel_valid(sel_valid3), .sel_ready(sel_ready3),
    .active_idx(active_idx3), .cs_b(cs_b3), .cs_b_chip(cs_b_chip3),
    .poci_chip(poci_chip3), .poci(poci3), .busy(busy3),
    .err_sel(err_sel3), .err_clr(err_clr3),
`ifdef SPI_BRIDGE_BROADCAST_EN
    .bcast(bcast3),
`endif
    .xfer_count(xfer_count3)
  );

  // Advance n rising edges and land 1 time unit after the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cs_b = 1'b1; sel_idx = '0; sel_valid = 1'b0; err_clr = 1'b0; poci_chip = '0;
    cs_b3 = 1'b1; sel_idx3 = '0; sel_valid3 = 1'b0; err_clr3 = 1'b0; poci_chip3 = '0;
`ifdef SPI_BRIDGE_BROADCAST_EN
    bcast = 1'b0; bcast3 = 1'b0;
`endif

    // Reset state
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cs", 32'(cs_b_chip), 32'hF);
    chk("rst_active", 32'(active_idx), 32'd0);
    chk("rst_err", 32'(err_sel), 32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    chk("rst_poci", 32'(poci), 32'd0);
    chk("rst_ready", 32'(sel_ready), 32'd0);
    rst = 1'b0;
    cyc(1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(sel_ready), 32'd1);

    // Frame on chip 0
    cs_b = 1'b0; poci_chip = 4'b0001; #1;
    chk("f0_cs_fall", 32'(cs_b_chip), 32'hE);
    chk("f0_poci_idle", 32'(poci), 32'd0);
    cyc(1);
    chk("f0_busy", 32'(busy), 32'd1);
    chk("f0_poci", 32'(poci), 32'd1);
    chk("f0_cs", 32'(cs_b_chip), 32'hE);
    cyc(9);
    chk("f0_cs_late", 32'(cs_b_chip), 32'hE);
    cs_b = 1'b1; #1;
    chk("f0_cs_rise", 32'(cs_b_chip), 32'hF);
    cyc(1);
    chk("f0_count", 32'(xfer_count), 32'd1);
    chk("f0_idle", 32'(busy), 32'd0);

    // Switch to chip 2 with a 2-cycle guard
    sel_idx = 2'd2; sel_valid = 1'b1; #1;
    chk("sw_ready", 32'(sel_ready), 32'd1);
    cyc(1);
    sel_valid = 1'b0; #1;
    chk("sw_active", 32'(active_idx), 32'd2);
    chk("g1_busy", 32'(busy), 32'd1);
    chk("g1_ready", 32'(sel_ready), 32'd0);
    chk("g1_cs", 32'(cs_b_chip), 32'hF);
    cyc(1);
    chk("g2_busy", 32'(busy), 32'd1);
    chk("g2_cs", 32'(cs_b_chip), 32'hF);
    cyc(1);
    chk("g_done", 32'(busy), 32'd0);
    cs_b = 1'b0; poci_chip = 4'b0100; #1;
    chk("f2_cs", 32'(cs_b_chip), 32'hB);
    cyc(1);
    chk("f2_poci", 32'(poci), 32'd1);
    cyc(3);
    cs_b = 1'b1;
    cyc(1);
    chk("f2_count", 32'(xfer_count), 32'd2);

    // Request held across a frame
    cs_b = 1'b0;
    cyc(1);
    sel_idx = 2'd1; sel_valid = 1'b1; #1;
    chk("hold_ready0", 32'(sel_ready), 32'd0);
    cyc(2);
    chk("hold_ready1", 32'(sel_ready), 32'd0);
    chk("hold_active", 32'(active_idx), 32'd2);
    cs_b = 1'b1; #1;
    chk("hold_ready2", 32'(sel_ready), 32'd0);
    cyc(1);
    chk("hold_ready3", 32'(sel_ready), 32'd1);
    chk("hold_active2", 32'(active_idx), 32'd2);
    chk("hold_count", 32'(xfer_count), 32'd3);
    cyc(1);
    sel_valid = 1'b0;
    chk("hold_switched", 32'(active_idx), 32'd1);

    // cs_b falls during guard
    cs_b = 1'b0; #1;
    chk("gv_cs", 32'(cs_b_chip), 32'hF);
    cyc(1);
    chk("gv_err", 32'(err_sel), 32'd1);
    chk("gv_busy", 32'(busy), 32'd1);
    cyc(3);
    chk("gv_cs_block", 32'(cs_b_chip), 32'hF);
    cs_b = 1'b1;
    cyc(1);
    chk("gv_idle", 32'(busy), 32'd0);
    chk("gv_count", 32'(xfer_count), 32'd3);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("gv_clr", 32'(err_sel), 32'd0);
    cs_b = 1'b0; #1;
    chk("f1_cs", 32'(cs_b_chip), 32'hD);
    cyc(1);
    cs_b = 1'b1;
    cyc(1);
    chk("f1_count", 32'(xfer_count), 32'd4);

    // Same-index request is a no-op
    sel_idx = 2'd1; sel_valid = 1'b1;
    cyc(1);
    sel_valid = 1'b0; #1;
    chk("noop_busy", 32'(busy), 32'd0);
    chk("noop_active", 32'(active_idx), 32'd1);

    // 3-chip instance: out-of-range index
    sel_idx3 = 2'd3; sel_valid3 = 1'b1;
    cyc(1);
    sel_valid3 = 1'b0; #1;
    chk("oor_err", 32'(err_sel3), 32'd1);
    chk("oor_active", 32'(active_idx3), 32'd0);
    chk("oor_busy", 32'(busy3), 32'd0);
    sel_idx3 = 2'd2; sel_valid3 = 1'b1;
    cyc(1);
    sel_valid3 = 1'b0; #1;
    chk("ng_active", 32'(active_idx3), 32'd2);
    chk("ng_busy", 32'(busy3), 32'd0);
    sel_idx3 = 2'd3; sel_valid3 = 1'b1; err_clr3 = 1'b1;
    cyc(1);
    sel_valid3 = 1'b0; #1;
    chk("set_wins", 32'(err_sel3), 32'd1);
    cyc(1);
    err_clr3 = 1'b0; #1;
    chk("clr3", 32'(err_sel3), 32'd0);

    // Saturating counter on the 2-bit instance
    for (int i = 0; i < 4; i++) begin
      cs_b3 = 1'b0;
      cyc(2);
      if (i == 0) chk("f3_cs", 32'(cs_b_chip3), 32'h3);
      cs_b3 = 1'b1;
      cyc(1);
      chk("sat_count", 32'(xfer_count3), (i < 3) ? 32'(i + 1) : 32'd3);
    end

`ifdef SPI_BRIDGE_BROADCAST_EN
    // Broadcast frame on the 3-chip instance
    bcast3 = 1'b1; cs_b3 = 1'b0; poci_chip3 = 3'b100; #1;
    chk("bc_cs_fall", 32'(cs_b_chip3), 32'h0);
    cyc(1);
    bcast3 = 1'b0; #1;
    chk("bc_cs", 32'(cs_b_chip3), 32'h0);
    chk("bc_poci", 32'(poci3), 32'd1);
    cs_b3 = 1'b1;
    cyc(1);
    chk("bc_end", 32'(cs_b_chip3), 32'h7);
`endif

    // Reset released mid-frame stays blocked
    rst = 1'b1; cs_b = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("rb_busy", 32'(busy), 32'd1);
    chk("rb_cs", 32'(cs_b_chip), 32'hF);
    chk("rb_count", 32'(xfer_count), 32'd0);
    cs_b = 1'b1;
    cyc(1);
    chk("rb_idle", 32'(busy), 32'd0);
    chk("rb_count2", 32'(xfer_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
